// File: rtl/periph_muldiv_pkg.sv
// Shared definitions for the multiply/divide peripheral: register map,
// control/status bit positions and the operation mode type.
package periph_muldiv_pkg;

   localparam logic [4:0] ADDR_OP_A   = 5'h00;
   localparam logic [4:0] ADDR_OP_B   = 5'h04;
   localparam logic [4:0] ADDR_CTRL   = 5'h08;
   localparam logic [4:0] ADDR_STATUS = 5'h0C;
   localparam logic [4:0] ADDR_RES_LO = 5'h10;
   localparam logic [4:0] ADDR_RES_HI = 5'h14;

   localparam int CTRL_START_BIT = 0;
   localparam int CTRL_MODE_BIT  = 1;
   localparam int CTRL_IE_BIT    = 2;

   localparam int STAT_DONE_BIT = 0;
   localparam int STAT_BUSY_BIT = 1;
   localparam int STAT_DZ_BIT   = 2;

   typedef enum logic {
      MODE_MUL = 1'b0,
      MODE_DIV = 1'b1
   } mode_e;

endpackage

// File: rtl/muldiv_seq_core.sv
// Radix-2 sequential engine: unsigned shift-add multiply or restoring divide,
// one result bit per clock over WIDTH clocks.
module muldiv_seq_core
   import periph_muldiv_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  mode_e            mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done_pulse,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi,
   output logic             dz
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   mode_e            mode_q, mode_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic             dz_q, dz_d;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shifted;

   // acc holds the product high half (mul) or partial remainder (div);
   // sh holds the multiplier shifting out / the dividend becoming the quotient.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      mode_d     = mode_q;
      opnd_d     = opnd_q;
      acc_d      = acc_q;
      sh_d       = sh_q;
      dz_d       = dz_q;
      done_pulse = 1'b0;
      sum        = '0;
      shifted    = '0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               cnt_d   = '0;
               mode_d  = mode;
               acc_d   = '0;
               dz_d    = (mode == MODE_DIV) && (b == '0);
               if (mode == MODE_MUL) begin
                  opnd_d = a;
                  sh_d   = b;
               end else begin
                  opnd_d = b;
                  sh_d   = a;
               end
            end
         end
         ST_RUN: begin
            if (mode_q == MODE_MUL) begin
               sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
               acc_d = sum[WIDTH:1];
               sh_d  = {sum[0], sh_q[WIDTH-1:1]};
            end else begin
               shifted = {acc_q, sh_q[WIDTH-1]};
               if (shifted >= {1'b0, opnd_q}) begin
                  acc_d = WIDTH'(shifted - {1'b0, opnd_q});
                  sh_d  = {sh_q[WIDTH-2:0], 1'b1};
               end else begin
                  acc_d = shifted[WIDTH-1:0];
                  sh_d  = {sh_q[WIDTH-2:0], 1'b0};
               end
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               done_pulse = 1'b1;
               state_d    = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         mode_q  <= MODE_MUL;
         opnd_q  <= '0;
         acc_q   <= '0;
         sh_q    <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         opnd_q  <= opnd_d;
         acc_q   <= acc_d;
         sh_q    <= sh_d;
         dz_q    <= dz_d;
      end
   end

   // The final iteration's values are exported so the caller can latch them on done_pulse.
   assign busy = (state_q == ST_RUN);
   assign lo   = sh_d;
   assign hi   = acc_d;
   assign dz   = dz_q;

endmodule

// File: rtl/peripheral_muldiv.sv
// Memory-mapped multiply/divide peripheral: bus decode, operand and control
// registers, sticky done/dz status, result holding registers and done interrupt.
module peripheral_muldiv
   import periph_muldiv_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] d_in,
   input  logic        cs,
   input  logic [4:0]  addr,
   input  logic        rd,
   input  logic        wr,
   output logic [31:0] d_out,
   output logic        irq
);

   logic [WIDTH-1:0] op_a_q, op_a_d;
   logic [WIDTH-1:0] op_b_q, op_b_d;
   mode_e            mode_q, mode_d;
   logic             ie_q, ie_d;
   logic             done_q, done_d;
   logic             dz_q, dz_d;
   logic [WIDTH-1:0] res_lo_q, res_lo_d;
   logic [WIDTH-1:0] res_hi_q, res_hi_d;
   logic             irq_q, irq_d;

   logic             start;
   logic             core_busy;
   logic             core_done;
   logic [WIDTH-1:0] core_lo;
   logic [WIDTH-1:0] core_hi;
   logic             core_dz;
   logic             unused_din;

   assign unused_din = ^d_in;

   // A start request while the core is running is silently dropped.
   assign start = cs && wr && (addr == ADDR_CTRL) && d_in[CTRL_START_BIT] && !core_busy;

   muldiv_seq_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .mode      (mode_e'(d_in[CTRL_MODE_BIT])),
      .a         (op_a_q),
      .b         (op_b_q),
      .busy      (core_busy),
      .done_pulse(core_done),
      .lo        (core_lo),
      .hi        (core_hi),
      .dz        (core_dz)
   );

   always_comb begin
      op_a_d   = op_a_q;
      op_b_d   = op_b_q;
      mode_d   = mode_q;
      ie_d     = ie_q;
      done_d   = done_q;
      dz_d     = dz_q;
      res_lo_d = res_lo_q;
      res_hi_d = res_hi_q;
      if (cs && wr) begin
         case (addr)
            ADDR_OP_A: op_a_d = d_in[WIDTH-1:0];
            ADDR_OP_B: op_b_d = d_in[WIDTH-1:0];
            ADDR_CTRL: begin
               mode_d = mode_e'(d_in[CTRL_MODE_BIT]);
               ie_d   = d_in[CTRL_IE_BIT];
            end
            default: ;
         endcase
      end
      if (start) begin
         done_d = 1'b0;
         dz_d   = 1'b0;
      end
      if (core_done) begin
         done_d   = 1'b1;
         dz_d     = core_dz;
         res_lo_d = core_lo;
         res_hi_d = core_hi;
      end
      irq_d = done_d & ie_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         op_a_q   <= '0;
         op_b_q   <= '0;
         mode_q   <= MODE_MUL;
         ie_q     <= 1'b0;
         done_q   <= 1'b0;
         dz_q     <= 1'b0;
         res_lo_q <= '0;
         res_hi_q <= '0;
         irq_q    <= 1'b0;
      end else begin
         op_a_q   <= op_a_d;
         op_b_q   <= op_b_d;
         mode_q   <= mode_d;
         ie_q     <= ie_d;
         done_q   <= done_d;
         dz_q     <= dz_d;
         res_lo_q <= res_lo_d;
         res_hi_q <= res_hi_d;
         irq_q    <= irq_d;
      end
   end

   always_comb begin
      d_out = '0;
      if (cs && rd) begin
         case (addr)
            ADDR_OP_A:   d_out = 32'(op_a_q);
            ADDR_OP_B:   d_out = 32'(op_b_q);
            ADDR_CTRL: begin
               d_out[CTRL_MODE_BIT] = (mode_q == MODE_DIV);
               d_out[CTRL_IE_BIT]   = ie_q;
            end
            ADDR_STATUS: begin
               d_out[STAT_DONE_BIT] = done_q;
               d_out[STAT_BUSY_BIT] = core_busy;
               d_out[STAT_DZ_BIT]   = dz_q;
            end
            ADDR_RES_LO: d_out = 32'(res_lo_q);
            ADDR_RES_HI: d_out = 32'(res_hi_q);
            default:     d_out = '0;
         endcase
      end
   end

   assign irq = irq_q;

endmodule

// File: tb/tb_peripheral_muldiv.sv
// Bench for peripheral_muldiv: 16- and 32-bit instances checked every cycle
// against an arithmetic model, plus directed literal checks and random traffic.
module tb_peripheral_muldiv;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] d_in = 32'h0;
   logic [4:0]  addr = 5'h0;
   logic        rd = 1'b0;
   logic        wr = 1'b0;
   logic        cs16 = 1'b0;
   logic        cs32 = 1'b0;
   logic [31:0] d_out16, d_out32;
   logic        irq16, irq32;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   peripheral_muldiv #(.WIDTH(16)) dut16 (
      .clk(clk), .reset(reset), .d_in(d_in), .cs(cs16), .addr(addr),
      .rd(rd), .wr(wr), .d_out(d_out16), .irq(irq16)
   );

   peripheral_muldiv #(.WIDTH(32)) dut32 (
      .clk(clk), .reset(reset), .d_in(d_in), .cs(cs32), .addr(addr),
      .rd(rd), .wr(wr), .d_out(d_out32), .irq(irq32)
   );

   // Architectural model state per instance (0 = 16-bit, 1 = 32-bit)
   logic [63:0] m_a [2];
   logic [63:0] m_b [2];
   logic [63:0] m_lo [2];
   logic [63:0] m_hi [2];
   logic [63:0] p_lo [2];
   logic [63:0] p_hi [2];
   logic        p_dz [2];
   logic        m_mode [2];
   logic        m_ie [2];
   logic        m_done [2];
   logic        m_dz [2];
   logic        m_irq [2];
   int          m_cnt [2];

   function automatic int widthOf(input int i);
      return (i == 0) ? 16 : 32;
   endfunction

   function automatic logic [63:0] maskOf(input int i);
      return (64'd1 << widthOf(i)) - 64'd1;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of the peripheral: the result appears WIDTH clocks after the
   // cycle following an accepted start, computed directly with * / %.
   task automatic modelStep(input int i, input logic sel);
      logic        was_busy;
      logic [63:0] p;
      logic [63:0] mk;
      int          w;
      w  = widthOf(i);
      mk = maskOf(i);
      if (reset) begin
         m_a[i] = 0; m_b[i] = 0; m_lo[i] = 0; m_hi[i] = 0;
         m_mode[i] = 0; m_ie[i] = 0; m_done[i] = 0; m_dz[i] = 0;
         m_irq[i] = 0; m_cnt[i] = 0;
         return;
      end
      was_busy = (m_cnt[i] > 0);
      if (was_busy) begin
         m_cnt[i]--;
         if (m_cnt[i] == 0) begin
            m_done[i] = 1'b1;
            m_lo[i]   = p_lo[i];
            m_hi[i]   = p_hi[i];
            m_dz[i]   = p_dz[i];
         end
      end
      if (sel && wr) begin
         case (addr)
            5'h00: m_a[i] = {32'h0, d_in} & mk;
            5'h04: m_b[i] = {32'h0, d_in} & mk;
            5'h08: begin
               m_mode[i] = d_in[1];
               m_ie[i]   = d_in[2];
               if (d_in[0] && !was_busy) begin
                  if (!d_in[1]) begin
                     p       = m_a[i] * m_b[i];
                     p_lo[i] = p & mk;
                     p_hi[i] = (p >> w) & mk;
                     p_dz[i] = 1'b0;
                  end else if (m_b[i] == 0) begin
                     p_lo[i] = mk;
                     p_hi[i] = m_a[i];
                     p_dz[i] = 1'b1;
                  end else begin
                     p_lo[i] = m_a[i] / m_b[i];
                     p_hi[i] = m_a[i] % m_b[i];
                     p_dz[i] = 1'b0;
                  end
                  m_cnt[i]  = w;
                  m_done[i] = 1'b0;
                  m_dz[i]   = 1'b0;
               end
            end
            default: ;
         endcase
      end
      m_irq[i] = m_done[i] & m_ie[i];
   endtask

   always @(posedge clk) begin
      modelStep(0, cs16);
      modelStep(1, cs32);
   end

   function automatic logic [31:0] expDout(input int i, input logic sel);
      if (!(sel && rd)) return 32'h0;
      case (addr)
         5'h00:   return m_a[i][31:0];
         5'h04:   return m_b[i][31:0];
         5'h08:   return {29'h0, m_ie[i], m_mode[i], 1'b0};
         5'h0C:   return {29'h0, m_dz[i], (m_cnt[i] > 0), m_done[i]};
         5'h10:   return m_lo[i][31:0];
         5'h14:   return m_hi[i][31:0];
         default: return 32'h0;
      endcase
   endfunction

   // Every cycle, mid-period, both instances' outputs must match the model.
   always @(negedge clk) begin
      checkOutput("d_out16", {32'h0, d_out16}, {32'h0, expDout(0, cs16)});
      checkOutput("irq16", {63'h0, irq16}, {63'h0, m_irq[0]});
      checkOutput("d_out32", {32'h0, d_out32}, {32'h0, expDout(1, cs32)});
      checkOutput("irq32", {63'h0, irq32}, {63'h0, m_irq[1]});
   end

   task automatic busWrite(input int i, input logic [4:0] a, input logic [31:0] v);
      cs16 = (i == 0);
      cs32 = (i == 1);
      addr = a;
      d_in = v;
      wr   = 1'b1;
      @(posedge clk);
      #1;
      wr   = 1'b0;
      cs16 = 1'b0;
      cs32 = 1'b0;
      d_in = 32'h0;
      addr = 5'h0;
   endtask

   task automatic busRead(input int i, input logic [4:0] a, output logic [31:0] v);
      cs16 = (i == 0);
      cs32 = (i == 1);
      addr = a;
      rd   = 1'b1;
      @(negedge clk);
      v = (i == 0) ? d_out16 : d_out32;
      @(posedge clk);
      #1;
      rd   = 1'b0;
      cs16 = 1'b0;
      cs32 = 1'b0;
      addr = 5'h0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic readCheck(input int i, input logic [4:0] a, input logic [31:0] exp, input string name);
      logic [31:0] v;
      busRead(i, a, v);
      checkOutput(name, {32'h0, v}, {32'h0, exp});
   endtask

   task automatic applyStimulus(input int i, input logic [31:0] a, input logic [31:0] b);
      busWrite(i, 5'h00, a);
      busWrite(i, 5'h04, b);
   endtask

   task automatic waitDone(input int i, input int budget);
      logic [31:0] v;
      int k;
      v = 32'h0;
      k = 0;
      while (!v[0] && k < budget) begin
         busRead(i, 5'h0C, v);
         k++;
      end
      if (!v[0]) checkOutput("waitDone timeout", {63'h0, v[0]}, 64'h1);
   endtask

   // Start in cycle T, then confirm busy at T+1 and T+W and done at T+W+1.
   task automatic timedRun(input int i, input logic [31:0] ctrl, input logic [31:0] done_status, input string tag);
      busWrite(i, 5'h08, ctrl);
      readCheck(i, 5'h0C, 32'h2, {tag, " busy at T+1"});
      idle(widthOf(i) - 2);
      readCheck(i, 5'h0C, 32'h2, {tag, " busy at T+W"});
      readCheck(i, 5'h0C, done_status, {tag, " done at T+W+1"});
   endtask

   initial begin
      #900000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [31:0] v, a, b, ctrl;
      int i, w, extra;

      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      checkOutput("irq after reset", {63'h0, irq16}, 64'h0);
      readCheck(0, 5'h0C, 32'h0, "status after reset");
      readCheck(0, 5'h10, 32'h0, "res_lo after reset");
      readCheck(0, 5'h08, 32'h0, "ctrl after reset");

      applyStimulus(0, 32'h1234, 32'h5678);
      timedRun(0, 32'h1, 32'h1, "mul16");
      readCheck(0, 5'h10, 32'h0060, "mul16 res_lo");
      readCheck(0, 5'h14, 32'h0626, "mul16 res_hi");

      applyStimulus(0, 32'hFFFF, 32'hFFFF);
      busWrite(0, 5'h08, 32'h1);
      waitDone(0, 30);
      readCheck(0, 5'h10, 32'h0001, "mulmax16 res_lo");
      readCheck(0, 5'h14, 32'hFFFE, "mulmax16 res_hi");
      readCheck(0, 5'h0C, 32'h1, "mulmax16 status");

      applyStimulus(0, 32'd1000, 32'd7);
      timedRun(0, 32'h3, 32'h1, "div16");
      readCheck(0, 5'h10, 32'd142, "div16 quotient");
      readCheck(0, 5'h14, 32'd6, "div16 remainder");
      applyStimulus(0, 32'h00AB, 32'h0);
      timedRun(0, 32'h3, 32'h5, "divz16");
      readCheck(0, 5'h10, 32'hFFFF, "divz16 quotient");
      readCheck(0, 5'h14, 32'h00AB, "divz16 remainder");

      applyStimulus(0, 32'h00FF, 32'h0101);
      busWrite(0, 5'h08, 32'h1);
      idle(4);
      busWrite(0, 5'h00, 32'h0);
      busWrite(0, 5'h08, 32'h1);
      idle(9);
      readCheck(0, 5'h0C, 32'h2, "restart ignored busy at T+16");
      readCheck(0, 5'h0C, 32'h1, "restart ignored done at T+17");
      readCheck(0, 5'h10, 32'hFFFF, "restart ignored res_lo");
      readCheck(0, 5'h14, 32'h0000, "restart ignored res_hi");
      readCheck(0, 5'h00, 32'h0, "op_a rewritten");

      applyStimulus(0, 32'd3, 32'd5);
      busWrite(0, 5'h08, 32'h5);
      waitDone(0, 30);
      checkOutput("irq with done", {63'h0, irq16}, 64'h1);
      readCheck(0, 5'h10, 32'd15, "irq test product");
      busWrite(0, 5'h08, 32'h0);
      checkOutput("irq after ie clear", {63'h0, irq16}, 64'h0);
      readCheck(0, 5'h0C, 32'h1, "done sticky read 1");
      readCheck(0, 5'h0C, 32'h1, "done sticky read 2");
      busWrite(0, 5'h08, 32'h4);
      checkOutput("irq after ie set", {63'h0, irq16}, 64'h1);

      applyStimulus(0, 32'd1000, 32'd7);
      busWrite(0, 5'h08, 32'h7);
      idle(7);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      checkOutput("irq after abort", {63'h0, irq16}, 64'h0);
      readCheck(0, 5'h0C, 32'h0, "status after abort");
      readCheck(0, 5'h10, 32'h0, "res_lo after abort");
      readCheck(0, 5'h14, 32'h0, "res_hi after abort");

      applyStimulus(1, 32'h1234, 32'h5678);
      timedRun(1, 32'h1, 32'h1, "mul32");
      readCheck(1, 5'h10, 32'h0626_0060, "mul32 res_lo");
      readCheck(1, 5'h14, 32'h0, "mul32 res_hi");
      applyStimulus(1, 32'd1000, 32'd7);
      timedRun(1, 32'h3, 32'h1, "div32");
      readCheck(1, 5'h10, 32'd142, "div32 quotient");
      readCheck(1, 5'h14, 32'd6, "div32 remainder");
      applyStimulus(1, 32'h00AB, 32'h0);
      busWrite(1, 5'h08, 32'h3);
      waitDone(1, 50);
      readCheck(1, 5'h10, 32'hFFFF_FFFF, "divz32 quotient");
      readCheck(1, 5'h14, 32'h00AB, "divz32 remainder");
      applyStimulus(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      busWrite(1, 5'h08, 32'h1);
      waitDone(1, 50);
      readCheck(1, 5'h10, 32'h1, "mulmax32 res_lo");
      readCheck(1, 5'h14, 32'hFFFF_FFFE, "mulmax32 res_hi");

      for (int n = 0; n < 60; n++) begin
         i = $urandom_range(0, 1);
         w = widthOf(i);
         a = $urandom;
         if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 20);
         case ($urandom_range(0, 3))
            0:       b = 32'h0;
            1:       b = $urandom_range(1, 15);
            default: b = $urandom;
         endcase
         ctrl = {29'h0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1};
         applyStimulus(i, a, b);
         busWrite(i, 5'h08, ctrl);
         extra = $urandom_range(0, 4);
         for (int k = 0; k < extra; k++) begin
            case ($urandom_range(0, 3))
               0:       busWrite(i, 5'h00, $urandom);
               1:       busWrite(i, 5'h04, $urandom);
               2:       busWrite(i, 5'h08, $urandom & 32'h7);
               default: busRead(i, 5'($urandom_range(0, 31)), v);
            endcase
         end
         waitDone(i, w + 10);
         busRead(i, 5'h10, v);
         busRead(i, 5'h14, v);
      end

      idle(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
